mig_app_arbiter: RTL and testbench
==================================

Name: mig_app_arbiter

Overview:
Shares the single MIG DDR user (app_*) interface between two requesters: a write port (sample loader filling DDR with waveform data) and a read port (playback engine fetching samples). Arbitrates round-robin, sequences app_en/app_cmd with the write-data channel (app_wdf_*), enforces a read-outstanding limit and returns read data in order. Sits directly between the sound-generator datapath and the MIG user interface. Issues nothing until init_calib_complete.

Parameters:
ADDR_WIDTH, 28, DDR app address width.
DATA_WIDTH, 128, app data width; mask width is DATA_WIDTH/8.
MAX_RD_OUTSTANDING, 8, maximum read commands accepted by MIG but not yet returned (power of 2, ≥2).

Ports:
clk  in  1  system clock (MIG ui_clk domain)
rst  in  1  synchronous active-high reset
init_calib_complete  in  1  MIG calibration done
wr_req  in  1  write request; wr_addr/wr_data/wr_mask held stable until wr_ack
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_mask  in  DATA_WIDTH/8  byte mask (1 = byte not written)
wr_ack  out  1  1-cycle pulse: write command and data both accepted by MIG
rd_req  in  1  read request; rd_addr held stable until rd_ack
rd_addr  in  ADDR_WIDTH  read address
rd_ack  out  1  1-cycle pulse: read command accepted by MIG
rd_data  out  DATA_WIDTH  returned read data
rd_data_valid  out  1  rd_data valid (1 cycle per beat)
rd_outstanding  out  $clog2(MAX_RD_OUTSTANDING)+1  current outstanding read count
rd_err  out  1  sticky: read data arrived with zero outstanding
app_rdy  in  1  MIG command accept
app_en  out  1  command valid
app_cmd  out  3  000 = write, 001 = read
app_addr  out  ADDR_WIDTH  command address
app_wdf_rdy  in  1  MIG write-data FIFO accept
app_wdf_wren  out  1  write data valid
app_wdf_end  out  1  last beat; always equal to app_wdf_wren (single-beat writes)
app_wdf_data  out  DATA_WIDTH  write data
app_wdf_mask  out  DATA_WIDTH/8  write mask
app_rd_data  in  DATA_WIDTH  MIG read data
app_rd_data_valid  in  1  MIG read data valid

Behaviour:
- Reset: all outputs 0 (app_cmd = 000, app_addr/app_wdf_* = 0, rd_outstanding = 0, rd_err = 0); state IDLE; last_grant = WRITE (so read wins first tie). Reset mid-transaction abandons it without ack.
- All outputs registered.
- FSM states: IDLE, WR, RD.
- IDLE: no grant while init_calib_complete = 0. Read eligible = rd_req && rd_outstanding < MAX_RD_OUTSTANDING. Only one eligible -> grant it. Both eligible -> grant the one not equal to last_grant. On grant, latch addr (and data/mask for writes), update last_grant, and next cycle assert app_en with app_cmd/app_addr (writes also assert app_wdf_wren/app_wdf_end with data/mask).
- WR: app_en held until a cycle with app_rdy = 1; app_wdf_wren held until a cycle with app_wdf_rdy = 1. The two channels complete independently, in either order or the same cycle; each deasserts the cycle after its own acceptance. When both are done, pulse wr_ack for 1 cycle and return to IDLE.
- RD: app_en held until app_rdy = 1. On acceptance, pulse rd_ack, increment rd_outstanding, return to IDLE.
- Command/data values are held stable while awaiting ready.
- Minimum latency is 3 cycles from grant to re-arbitration: grant, issue/accept, ack.
- Read return: rd_data/rd_data_valid = app_rd_data/app_rd_data_valid delayed by 1 register stage, in order. app_rd_data_valid decrements rd_outstanding.
- A read accept and a data return in the same cycle leave rd_outstanding unchanged.
- Data return when rd_outstanding = 0: counter stays 0, rd_err sets and stays set until reset; data is still forwarded.
- rd_outstanding = MAX blocks read grants only; writes continue.
- Requesters dropping req before ack is illegal. An already-granted transaction completes regardless.
- init_calib_complete falling mid-transaction: the current transaction completes; no new grants.

Test Plan:
- Calibration gate: wr_req = 1, init_calib_complete = 0 for 20 cycles -> app_en stays 0. Raise calibration -> app_en = 1 with app_cmd = 000 next cycle after grant.
- Single write: app_rdy = 1, app_wdf_rdy = 0 for 5 cycles -> app_en drops after 1 cycle, app_wdf_wren is held 5 more cycles, and wr_ack pulses once after app_wdf_rdy = 1 with app_addr/data/mask matching inputs.
- Round-robin: wr_req and rd_req both held continuously -> grants alternate R, W, R, W…, with the first grant read after reset.
- Outstanding limit: MAX = 8, no read returns -> exactly 8 rd_acks and rd_outstanding = 8, then no app_en for reads. One app_rd_data_valid -> a 9th read is issued.
- Simultaneous accept/return: rd_outstanding = 3, read accept in the same cycle as app_rd_data_valid -> stays 3. rd_data appears 1 cycle after app_rd_data.
- Spurious return: app_rd_data_valid with rd_outstanding = 0 -> rd_err = 1 (sticky), counter 0. Assert rst mid-WR -> all outputs 0 next cycle and no wr_ack.

Source files
------------

// File: rtl/mig_app_arbiter_if.sv
`default_nettype none
// ============================================================================
// mig_app_arbiter_if : requester ports plus MIG app_* bus for mig_app_arbiter
// Revision: 1.0
// ============================================================================
interface mig_app_arbiter_if #(
   parameter int ADDR_WIDTH         = 28,
   parameter int DATA_WIDTH         = 128,
   parameter int MAX_RD_OUTSTANDING = 8
);
   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_WIDTH  = $clog2(MAX_RD_OUTSTANDING) + 1;

   logic                  init_calib_complete_i;
   logic                  wr_req_i;
   logic [ADDR_WIDTH-1:0] wr_addr_i;
   logic [DATA_WIDTH-1:0] wr_data_i;
   logic [MASK_WIDTH-1:0] wr_mask_i;
   logic                  wr_ack_o;
   logic                  rd_req_i;
   logic [ADDR_WIDTH-1:0] rd_addr_i;
   logic                  rd_ack_o;
   logic [DATA_WIDTH-1:0] rd_data_o;
   logic                  rd_data_valid_o;
   logic [CNT_WIDTH-1:0]  rd_outstanding_o;
   logic                  rd_err_o;
   logic                  app_rdy_i;
   logic                  app_en_o;
   logic [2:0]            app_cmd_o;
   logic [ADDR_WIDTH-1:0] app_addr_o;
   logic                  app_wdf_rdy_i;
   logic                  app_wdf_wren_o;
   logic                  app_wdf_end_o;
   logic [DATA_WIDTH-1:0] app_wdf_data_o;
   logic [MASK_WIDTH-1:0] app_wdf_mask_o;
   logic [DATA_WIDTH-1:0] app_rd_data_i;
   logic                  app_rd_data_valid_i;

   // slave is the arbiter's view; master is the requesters and MIG around it
   modport slave (
      input  init_calib_complete_i, wr_req_i, wr_addr_i, wr_data_i, wr_mask_i,
      input  rd_req_i, rd_addr_i, app_rdy_i, app_wdf_rdy_i,
      input  app_rd_data_i, app_rd_data_valid_i,
      output wr_ack_o, rd_ack_o, rd_data_o, rd_data_valid_o, rd_outstanding_o, rd_err_o,
      output app_en_o, app_cmd_o, app_addr_o, app_wdf_wren_o, app_wdf_end_o,
      output app_wdf_data_o, app_wdf_mask_o
   );

   modport master (
      output init_calib_complete_i, wr_req_i, wr_addr_i, wr_data_i, wr_mask_i,
      output rd_req_i, rd_addr_i, app_rdy_i, app_wdf_rdy_i,
      output app_rd_data_i, app_rd_data_valid_i,
      input  wr_ack_o, rd_ack_o, rd_data_o, rd_data_valid_o, rd_outstanding_o, rd_err_o,
      input  app_en_o, app_cmd_o, app_addr_o, app_wdf_wren_o, app_wdf_end_o,
      input  app_wdf_data_o, app_wdf_mask_o
   );
endinterface
`default_nettype wire

// File: rtl/mig_app_arbiter.sv
`default_nettype none
// ============================================================================
// mig_app_arbiter : round-robin write/read sharing of one MIG app interface
// Revision: 1.0
// ============================================================================
module mig_app_arbiter #(
   parameter int ADDR_WIDTH         = 28,
   parameter int DATA_WIDTH         = 128,
   parameter int MAX_RD_OUTSTANDING = 8
) (
   input  logic             clk,
   input  logic             rst,
   mig_app_arbiter_if.slave bus
);
   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_WIDTH  = $clog2(MAX_RD_OUTSTANDING) + 1;
   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_RD_OUTSTANDING);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WR   = 2'd1;
   localparam logic [1:0] S_RD   = 2'd2;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   localparam logic GRANT_RD = 1'b0;
   localparam logic GRANT_WR = 1'b1;

   logic [1:0]            state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  app_en_q, app_en_d;
   logic [2:0]            app_cmd_q, app_cmd_d;
   logic [ADDR_WIDTH-1:0] app_addr_q, app_addr_d;
   logic                  wdf_wren_q, wdf_wren_d;
   logic [DATA_WIDTH-1:0] wdf_data_q, wdf_data_d;
   logic [MASK_WIDTH-1:0] wdf_mask_q, wdf_mask_d;
   logic                  wr_ack_q, wr_ack_d;
   logic                  rd_ack_q, rd_ack_d;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_data_valid_q;
   logic [CNT_WIDTH-1:0]  rd_out_q, rd_out_d;
   logic                  rd_err_q, rd_err_d;

   logic w_arb_open;
   logic w_rd_eligible;
   logic w_grant_rd;
   logic w_grant_wr;
   logic w_cmd_accept;
   logic w_wdf_accept;
   logic w_wr_done;
   logic w_rd_done;
   logic w_rd_return;

   // An ack pulse blocks arbitration for its cycle: the requester still shows
   // its old req then, and granting it would issue the same transfer twice.
   assign w_arb_open    = (state_q == S_IDLE) && bus.init_calib_complete_i
                          && !wr_ack_q && !rd_ack_q;
   assign w_rd_eligible = bus.rd_req_i && (rd_out_q < MAX_CNT);
   assign w_grant_rd    = w_arb_open && w_rd_eligible
                          && (!bus.wr_req_i || (last_grant_q == GRANT_WR));
   assign w_grant_wr    = w_arb_open && bus.wr_req_i && !w_grant_rd;

   assign w_cmd_accept  = app_en_q && bus.app_rdy_i;
   assign w_wdf_accept  = wdf_wren_q && bus.app_wdf_rdy_i;
   assign w_wr_done     = (state_q == S_WR)
                          && (!app_en_q || w_cmd_accept)
                          && (!wdf_wren_q || w_wdf_accept);
   assign w_rd_done     = (state_q == S_RD) && w_cmd_accept;
   assign w_rd_return   = bus.app_rd_data_valid_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (w_grant_wr) begin
               state_d = S_WR;
            end else if (w_grant_rd) begin
               state_d = S_RD;
            end
         end
         S_WR:    if (w_wr_done) state_d = S_IDLE;
         S_RD:    if (w_rd_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      app_en_d     = app_en_q;
      app_cmd_d    = app_cmd_q;
      app_addr_d   = app_addr_q;
      wdf_wren_d   = wdf_wren_q;
      wdf_data_d   = wdf_data_q;
      wdf_mask_d   = wdf_mask_q;

      if (w_grant_wr) begin
         last_grant_d = GRANT_WR;
         app_en_d     = 1'b1;
         app_cmd_d    = CMD_WRITE;
         app_addr_d   = bus.wr_addr_i;
         wdf_wren_d   = 1'b1;
         wdf_data_d   = bus.wr_data_i;
         wdf_mask_d   = bus.wr_mask_i;
      end else if (w_grant_rd) begin
         last_grant_d = GRANT_RD;
         app_en_d     = 1'b1;
         app_cmd_d    = CMD_READ;
         app_addr_d   = bus.rd_addr_i;
      end

      // Command and write-data channels retire independently
      if (w_cmd_accept) app_en_d   = 1'b0;
      if (w_wdf_accept) wdf_wren_d = 1'b0;

      wr_ack_d = w_wr_done;
      rd_ack_d = w_rd_done;

      rd_out_d = rd_out_q;
      if (w_rd_done && !(w_rd_return && (rd_out_q != '0))) begin
         rd_out_d = rd_out_q + CNT_WIDTH'(1);
      end else if (!w_rd_done && w_rd_return && (rd_out_q != '0)) begin
         rd_out_d = rd_out_q - CNT_WIDTH'(1);
      end

      rd_err_d = rd_err_q | (w_rd_return && (rd_out_q == '0));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q    <= GRANT_WR;
         app_en_q        <= 1'b0;
         app_cmd_q       <= CMD_WRITE;
         app_addr_q      <= '0;
         wdf_wren_q      <= 1'b0;
         wdf_data_q      <= '0;
         wdf_mask_q      <= '0;
         wr_ack_q        <= 1'b0;
         rd_ack_q        <= 1'b0;
         rd_data_q       <= '0;
         rd_data_valid_q <= 1'b0;
         rd_out_q        <= '0;
         rd_err_q        <= 1'b0;
      end else begin
         last_grant_q    <= last_grant_d;
         app_en_q        <= app_en_d;
         app_cmd_q       <= app_cmd_d;
         app_addr_q      <= app_addr_d;
         wdf_wren_q      <= wdf_wren_d;
         wdf_data_q      <= wdf_data_d;
         wdf_mask_q      <= wdf_mask_d;
         wr_ack_q        <= wr_ack_d;
         rd_ack_q        <= rd_ack_d;
         rd_data_q       <= bus.app_rd_data_i;
         rd_data_valid_q <= bus.app_rd_data_valid_i;
         rd_out_q        <= rd_out_d;
         rd_err_q        <= rd_err_d;
      end
   end

   assign bus.app_en_o         = app_en_q;
   assign bus.app_cmd_o        = app_cmd_q;
   assign bus.app_addr_o       = app_addr_q;
   assign bus.app_wdf_wren_o   = wdf_wren_q;
   assign bus.app_wdf_end_o    = wdf_wren_q;
   assign bus.app_wdf_data_o   = wdf_data_q;
   assign bus.app_wdf_mask_o   = wdf_mask_q;
   assign bus.wr_ack_o         = wr_ack_q;
   assign bus.rd_ack_o         = rd_ack_q;
   assign bus.rd_data_o        = rd_data_q;
   assign bus.rd_data_valid_o  = rd_data_valid_q;
   assign bus.rd_outstanding_o = rd_out_q;
   assign bus.rd_err_o         = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mig_app_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mig_app_arbiter : directed scenarios plus randomized traffic vs memory model
// Revision: 1.0
// ============================================================================
module tb_mig_app_arbiter;
   localparam int AW  = 28;
   localparam int DW  = 128;
   localparam int MAX = 8;
   localparam int MW  = DW / 8;
   localparam int CW  = $clog2(MAX) + 1;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mig_app_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RD_OUTSTANDING(MAX)) bus ();

   mig_app_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RD_OUTSTANDING(MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [DW-1:0] ref_mem [16];
   logic [DW-1:0] mig_mem [16];

   function automatic logic [DW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [DW-1:0] apply_mask(input logic [DW-1:0] old,
                                                input logic [DW-1:0] d,
                                                input logic [MW-1:0] m);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < MW; b++) if (!m[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.init_calib_complete_i = 1'b0;
      bus.wr_req_i = 1'b0;  bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.wr_mask_i = '0;
      bus.rd_req_i = 1'b0;  bus.rd_addr_i = '0;
      bus.app_rdy_i = 1'b0; bus.app_wdf_rdy_i = 1'b0;
      bus.app_rd_data_i = '0; bus.app_rd_data_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      bus.init_calib_complete_i = 1'b1;
      bus.wr_req_i = 1'b1; bus.rd_req_i = 1'b1;
      bus.wr_addr_i = AW'($urandom); bus.wr_data_i = rand_data(); bus.wr_mask_i = MW'($urandom);
      bus.app_rdy_i = 1'b1; bus.app_wdf_rdy_i = 1'b1;
      bus.app_rd_data_valid_i = 1'b1; bus.app_rd_data_i = rand_data();
      repeat (3) tick();
      checks++; if (bus.app_en_o !== 1'b0) begin errors++; $display("FAIL reset_app_en got %0b want 0", bus.app_en_o); end
      checks++; if (bus.app_cmd_o !== 3'b000 || bus.app_addr_o !== '0) begin errors++; $display("FAIL reset_cmd_addr got %0b/%0h want 0/0", bus.app_cmd_o, bus.app_addr_o); end
      checks++; if (bus.app_wdf_wren_o !== 1'b0 || bus.app_wdf_end_o !== 1'b0) begin errors++; $display("FAIL reset_wdf_wren got %0b/%0b want 0/0", bus.app_wdf_wren_o, bus.app_wdf_end_o); end
      checks++; if (bus.app_wdf_data_o !== '0 || bus.app_wdf_mask_o !== '0) begin errors++; $display("FAIL reset_wdf_data got %0h/%0h want 0/0", bus.app_wdf_data_o, bus.app_wdf_mask_o); end
      checks++; if (bus.wr_ack_o !== 1'b0 || bus.rd_ack_o !== 1'b0) begin errors++; $display("FAIL reset_acks got %0b/%0b want 0/0", bus.wr_ack_o, bus.rd_ack_o); end
      checks++; if (bus.rd_data_o !== '0 || bus.rd_data_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rd_data got %0h/%0b want 0/0", bus.rd_data_o, bus.rd_data_valid_o); end
      checks++; if (bus.rd_outstanding_o !== '0 || bus.rd_err_o !== 1'b0) begin errors++; $display("FAIL reset_rd_cnt got %0d/%0b want 0/0", bus.rd_outstanding_o, bus.rd_err_o); end
      clear_inputs();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_calib_gate();
      logic [AW-1:0] a; logic [DW-1:0] d; logic [MW-1:0] m; bit seen;
      do_reset();
      a = AW'($urandom); d = rand_data(); m = MW'($urandom);
      bus.wr_req_i = 1'b1; bus.wr_addr_i = a; bus.wr_data_i = d; bus.wr_mask_i = m;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++; if (bus.app_en_o !== 1'b0) begin errors++; $display("FAIL calib_gate_en cycle %0d got %0b want 0", i, bus.app_en_o); end
      end
      bus.init_calib_complete_i = 1'b1;
      tick();
      checks++; if (bus.app_en_o !== 1'b1 || bus.app_cmd_o !== 3'b000) begin errors++; $display("FAIL calib_issue got en=%0b cmd=%0b want 1/000", bus.app_en_o, bus.app_cmd_o); end
      checks++; if (bus.app_addr_o !== a || bus.app_wdf_data_o !== d || bus.app_wdf_mask_o !== m) begin errors++; $display("FAIL calib_payload got %0h/%0h/%0h want %0h/%0h/%0h", bus.app_addr_o, bus.app_wdf_data_o, bus.app_wdf_mask_o, a, d, m); end
      checks++; if (bus.app_wdf_wren_o !== 1'b1 || bus.app_wdf_end_o !== 1'b1) begin errors++; $display("FAIL calib_wren got %0b/%0b want 1/1", bus.app_wdf_wren_o, bus.app_wdf_end_o); end
      bus.app_rdy_i = 1'b1; bus.app_wdf_rdy_i = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = bus.wr_ack_o; end
      checks++; if (!seen) begin errors++; $display("FAIL calib_wr_ack got none want pulse"); end
      clear_inputs();
      tick();
   endtask

   task automatic test_single_write();
      logic [AW-1:0] a; logic [DW-1:0] d; logic [MW-1:0] m; int acks;
      do_reset();
      a = AW'($urandom); d = rand_data(); m = MW'($urandom);
      bus.init_calib_complete_i = 1'b1; bus.app_rdy_i = 1'b1; bus.app_wdf_rdy_i = 1'b0;
      bus.wr_req_i = 1'b1; bus.wr_addr_i = a; bus.wr_data_i = d; bus.wr_mask_i = m;
      tick();
      checks++; if (bus.app_en_o !== 1'b1 || bus.app_addr_o !== a || bus.app_wdf_data_o !== d || bus.app_wdf_mask_o !== m)
         begin errors++; $display("FAIL sw_issue got en=%0b %0h/%0h/%0h want 1 %0h/%0h/%0h", bus.app_en_o, bus.app_addr_o, bus.app_wdf_data_o, bus.app_wdf_mask_o, a, d, m); end
      tick();
      checks++; if (bus.app_en_o !== 1'b0) begin errors++; $display("FAIL sw_en_drop got %0b want 0", bus.app_en_o); end
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.app_wdf_wren_o !== 1'b1 || bus.app_wdf_data_o !== d) begin errors++; $display("FAIL sw_wren_hold cycle %0d got %0b want 1", i, bus.app_wdf_wren_o); end
         if (bus.wr_ack_o) acks++;
         if (i < 4) tick();
      end
      bus.app_wdf_rdy_i = 1'b1;
      tick();
      checks++; if (bus.wr_ack_o !== 1'b1 || bus.app_wdf_wren_o !== 1'b0) begin errors++; $display("FAIL sw_ack got ack=%0b wren=%0b want 1/0", bus.wr_ack_o, bus.app_wdf_wren_o); end
      bus.wr_req_i = 1'b0;
      for (int i = 0; i < 4; i++) begin tick(); if (bus.wr_ack_o) acks++; end
      checks++; if (acks != 0) begin errors++; $display("FAIL sw_ack_once got %0d extra want 0", acks); end
      clear_inputs();
   endtask

   task automatic test_round_robin();
      logic [2:0] got [6]; int n; logic prev_en;
      do_reset();
      bus.init_calib_complete_i = 1'b1; bus.app_rdy_i = 1'b1; bus.app_wdf_rdy_i = 1'b1;
      bus.wr_req_i = 1'b1; bus.rd_req_i = 1'b1;
      bus.wr_addr_i = AW'($urandom); bus.rd_addr_i = AW'($urandom); bus.wr_data_i = rand_data();
      n = 0; prev_en = 1'b0;
      for (int i = 0; i < 60 && n < 6; i++) begin
         tick();
         if (bus.app_en_o && !prev_en) begin got[n] = bus.app_cmd_o; n++; end
         prev_en = bus.app_en_o;
      end
      checks++; if (n != 6) begin errors++; $display("FAIL rr_grants got %0d want 6", n); end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (got[i] !== ((i % 2 == 0) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL rr_order grant %0d got %0b want %0b", i, got[i], (i % 2 == 0) ? 3'b001 : 3'b000); end
      end
      clear_inputs();
   endtask

   task automatic test_outstanding_limit();
      int racks, ens; bit seen;
      do_reset();
      bus.init_calib_complete_i = 1'b1; bus.app_rdy_i = 1'b1; bus.app_wdf_rdy_i = 1'b1;
      bus.rd_req_i = 1'b1; bus.rd_addr_i = AW'($urandom);
      racks = 0; ens = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (bus.rd_ack_o) racks++;
         if (bus.app_en_o) ens++;
      end
      checks++; if (racks != MAX || ens != MAX) begin errors++; $display("FAIL lim_reads got acks=%0d en=%0d want %0d", racks, ens, MAX); end
      checks++; if (bus.rd_outstanding_o !== CW'(MAX)) begin errors++; $display("FAIL lim_count got %0d want %0d", bus.rd_outstanding_o, MAX); end
      bus.wr_req_i = 1'b1; bus.wr_addr_i = AW'($urandom); bus.wr_data_i = rand_data();
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = bus.wr_ack_o; if (bus.rd_ack_o) racks++; end
      checks++; if (!seen || racks != MAX) begin errors++; $display("FAIL lim_write got ack=%0b reads=%0d want 1/%0d", seen, racks, MAX); end
      bus.wr_req_i = 1'b0;
      tick();
      bus.app_rd_data_valid_i = 1'b1; bus.app_rd_data_i = rand_data();
      tick();
      bus.app_rd_data_valid_i = 1'b0;
      racks = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (bus.rd_ack_o) racks++; end
      checks++; if (racks != 1 || bus.rd_outstanding_o !== CW'(MAX)) begin errors++; $display("FAIL lim_ninth got acks=%0d cnt=%0d want 1/%0d", racks, bus.rd_outstanding_o, MAX); end
      clear_inputs();
   endtask

   task automatic test_simultaneous();
      int racks; logic [DW-1:0] x;
      do_reset();
      bus.init_calib_complete_i = 1'b1; bus.app_rdy_i = 1'b1;
      bus.rd_req_i = 1'b1; bus.rd_addr_i = AW'($urandom);
      racks = 0;
      for (int i = 0; i < 30 && racks < 3; i++) begin
         tick();
         if (bus.rd_ack_o) begin racks++; if (racks == 3) bus.rd_req_i = 1'b0; end
      end
      bus.app_rdy_i = 1'b0;
      tick();
      checks++; if (bus.rd_outstanding_o !== CW'(3)) begin errors++; $display("FAIL sim_pre_count got %0d want 3", bus.rd_outstanding_o); end
      bus.rd_req_i = 1'b1; bus.rd_addr_i = AW'($urandom);
      tick();
      checks++; if (bus.app_en_o !== 1'b1 || bus.app_cmd_o !== 3'b001) begin errors++; $display("FAIL sim_issue got en=%0b cmd=%0b want 1/001", bus.app_en_o, bus.app_cmd_o); end
      x = rand_data();
      bus.app_rdy_i = 1'b1; bus.app_rd_data_valid_i = 1'b1; bus.app_rd_data_i = x;
      tick();
      bus.rd_req_i = 1'b0; bus.app_rd_data_valid_i = 1'b0; bus.app_rd_data_i = rand_data();
      checks++; if (bus.rd_ack_o !== 1'b1 || bus.rd_outstanding_o !== CW'(3)) begin errors++; $display("FAIL sim_count got ack=%0b cnt=%0d want 1/3", bus.rd_ack_o, bus.rd_outstanding_o); end
      checks++; if (bus.rd_data_valid_o !== 1'b1 || bus.rd_data_o !== x) begin errors++; $display("FAIL sim_rd_data got %0b/%0h want 1/%0h", bus.rd_data_valid_o, bus.rd_data_o, x); end
      tick();
      checks++; if (bus.rd_data_valid_o !== 1'b0) begin errors++; $display("FAIL sim_rd_valid_drop got %0b want 0", bus.rd_data_valid_o); end
      clear_inputs();
   endtask

   task automatic test_spurious_and_reset();
      logic [DW-1:0] y; bit bad;
      do_reset();
      bus.init_calib_complete_i = 1'b1;
      y = rand_data();
      bus.app_rd_data_valid_i = 1'b1; bus.app_rd_data_i = y;
      tick();
      bus.app_rd_data_valid_i = 1'b0;
      checks++; if (bus.rd_err_o !== 1'b1 || bus.rd_outstanding_o !== '0) begin errors++; $display("FAIL spur_err got err=%0b cnt=%0d want 1/0", bus.rd_err_o, bus.rd_outstanding_o); end
      checks++; if (bus.rd_data_valid_o !== 1'b1 || bus.rd_data_o !== y) begin errors++; $display("FAIL spur_fwd got %0b/%0h want 1/%0h", bus.rd_data_valid_o, bus.rd_data_o, y); end
      repeat (3) tick();
      checks++; if (bus.rd_err_o !== 1'b1) begin errors++; $display("FAIL spur_sticky got %0b want 1", bus.rd_err_o); end
      bus.wr_req_i = 1'b1; bus.wr_addr_i = AW'($urandom) | AW'(1); bus.wr_data_i = rand_data() | DW'(1); bus.wr_mask_i = MW'(16'h00f0);
      tick();
      tick();
      checks++; if (bus.app_en_o !== 1'b1 || bus.app_wdf_wren_o !== 1'b1) begin errors++; $display("FAIL rst_wr_pending got %0b/%0b want 1/1", bus.app_en_o, bus.app_wdf_wren_o); end
      rst = 1'b1;
      tick();
      checks++; if (bus.app_en_o !== 1'b0 || bus.app_wdf_wren_o !== 1'b0 || bus.app_wdf_end_o !== 1'b0 || bus.wr_ack_o !== 1'b0)
         begin errors++; $display("FAIL rst_mid_ctrl got en=%0b wren=%0b end=%0b ack=%0b want 0", bus.app_en_o, bus.app_wdf_wren_o, bus.app_wdf_end_o, bus.wr_ack_o); end
      checks++; if (bus.app_addr_o !== '0 || bus.app_wdf_data_o !== '0 || bus.app_wdf_mask_o !== '0 || bus.rd_err_o !== 1'b0)
         begin errors++; $display("FAIL rst_mid_data got %0h/%0h/%0h err=%0b want 0", bus.app_addr_o, bus.app_wdf_data_o, bus.app_wdf_mask_o, bus.rd_err_o); end
      rst = 1'b0; bus.wr_req_i = 1'b0; bus.app_rdy_i = 1'b1; bus.app_wdf_rdy_i = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin tick(); if (bus.wr_ack_o || bus.app_en_o) bad = 1; end
      checks++; if (bad) begin errors++; $display("FAIL rst_abandon got activity want none"); end
      clear_inputs();
   endtask

   // Requesters and a MIG model with a memory each; reads must return what the
   // requester-side view of memory holds at the time its read was acknowledged.
   task automatic test_random_traffic();
      logic [AW-1:0] wr_a, rd_a, mig_wa, caddr;
      logic [DW-1:0] wr_d, mig_wd, d, exp;
      logic [MW-1:0] wr_m, mig_wm, m;
      logic [2:0]    cmd;
      logic [DW-1:0] ret_q [$];
      int            ret_t [$];
      logic [DW-1:0] exp_q [$];
      bit wr_pend, rd_pend, wr_cmd_seen, wr_dat_seen, rd_cmd_seen, mig_wc, mig_wdg;
      bit cmd_fire, dat_fire, ret_fire, drain, done;
      int model_out, cyc;
      do_reset();
      for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; mig_mem[i] = '0; end
      wr_pend = 0; rd_pend = 0; wr_cmd_seen = 0; wr_dat_seen = 0; rd_cmd_seen = 0;
      mig_wc = 0; mig_wdg = 0; model_out = 0; cyc = 0; drain = 0; done = 0;
      wr_a = '0; rd_a = '0; wr_d = '0; wr_m = '0; mig_wa = '0; mig_wd = '0; mig_wm = '0;
      while (!done && cyc < 3500) begin
         @(negedge clk);
         cmd_fire = bus.app_en_o && bus.app_rdy_i; cmd = bus.app_cmd_o; caddr = bus.app_addr_o;
         dat_fire = bus.app_wdf_wren_o && bus.app_wdf_rdy_i; d = bus.app_wdf_data_o; m = bus.app_wdf_mask_o;
         ret_fire = bus.app_rd_data_valid_i;
         tick();
         cyc++;
         if (cmd_fire) begin
            checks++;
            if (cmd == 3'b000) begin
               if (!wr_pend || wr_cmd_seen || caddr !== wr_a) begin errors++; $display("FAIL rnd_wr_cmd got addr %0h want %0h", caddr, wr_a); end
               wr_cmd_seen = 1; mig_wc = 1; mig_wa = caddr;
            end else if (cmd == 3'b001) begin
               if (!rd_pend || rd_cmd_seen || caddr !== rd_a || model_out >= MAX) begin errors++; $display("FAIL rnd_rd_cmd got addr %0h out %0d want %0h", caddr, model_out, rd_a); end
               rd_cmd_seen = 1;
               ret_q.push_back(mig_mem[caddr[3:0]]);
               ret_t.push_back(cyc + int'($urandom_range(1, 6)));
               model_out++;
            end else begin
               errors++; $display("FAIL rnd_cmd_code got %0b want 000 or 001", cmd);
            end
         end
         if (dat_fire) begin
            checks++;
            if (!wr_pend || wr_dat_seen || d !== wr_d || m !== wr_m) begin errors++; $display("FAIL rnd_wdf got %0h/%0h want %0h/%0h", d, m, wr_d, wr_m); end
            wr_dat_seen = 1; mig_wdg = 1; mig_wd = d; mig_wm = m;
         end
         if (mig_wc && mig_wdg) begin
            mig_mem[mig_wa[3:0]] = apply_mask(mig_mem[mig_wa[3:0]], mig_wd, mig_wm);
            mig_wc = 0; mig_wdg = 0;
         end
         if (ret_fire && model_out > 0) model_out--;

         checks++; if (bus.rd_outstanding_o !== CW'(model_out)) begin errors++; $display("FAIL rnd_outstanding cycle %0d got %0d want %0d", cyc, bus.rd_outstanding_o, model_out); end
         if (bus.wr_ack_o) begin
            checks++; if (!wr_pend || !wr_cmd_seen || !wr_dat_seen) begin errors++; $display("FAIL rnd_wr_ack early cmd=%0b dat=%0b want 1/1", wr_cmd_seen, wr_dat_seen); end
            ref_mem[wr_a[3:0]] = apply_mask(ref_mem[wr_a[3:0]], wr_d, wr_m);
            wr_pend = 0;
         end
         if (bus.rd_ack_o) begin
            checks++; if (!rd_pend || !rd_cmd_seen) begin errors++; $display("FAIL rnd_rd_ack early cmd=%0b want 1", rd_cmd_seen); end
            exp_q.push_back(ref_mem[rd_a[3:0]]);
            rd_pend = 0;
         end
         if (bus.rd_data_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_rd_data got %0h want none", bus.rd_data_o); end
            else begin
               exp = exp_q.pop_front();
               if (bus.rd_data_o !== exp) begin errors++; $display("FAIL rnd_rd_data got %0h want %0h", bus.rd_data_o, exp); end
            end
         end
         checks++; if (bus.rd_err_o !== 1'b0) begin errors++; $display("FAIL rnd_rd_err got %0b want 0", bus.rd_err_o); end

         if (cyc >= 3000) drain = 1;
         if (!drain && !wr_pend && $urandom_range(0, 2) == 0) begin
            wr_pend = 1; wr_cmd_seen = 0; wr_dat_seen = 0;
            wr_a = AW'($urandom_range(0, 15)); wr_d = rand_data(); wr_m = MW'($urandom);
         end
         if (!drain && !rd_pend && $urandom_range(0, 1) == 0) begin
            rd_pend = 1; rd_cmd_seen = 0; rd_a = AW'($urandom_range(0, 15));
         end
         bus.wr_req_i = wr_pend; bus.wr_addr_i = wr_a; bus.wr_data_i = wr_d; bus.wr_mask_i = wr_m;
         bus.rd_req_i = rd_pend; bus.rd_addr_i = rd_a;
         bus.init_calib_complete_i = drain || ($urandom_range(0, 7) != 0);
         bus.app_rdy_i     = drain || ($urandom_range(0, 3) != 0);
         bus.app_wdf_rdy_i = drain || ($urandom_range(0, 3) != 0);
         if (ret_q.size() > 0 && ret_t[0] <= cyc && $urandom_range(0, 1) == 0) begin
            bus.app_rd_data_valid_i = 1'b1;
            bus.app_rd_data_i = ret_q.pop_front();
            void'(ret_t.pop_front());
         end else begin
            bus.app_rd_data_valid_i = 1'b0;
            bus.app_rd_data_i = rand_data();
         end
         if (drain && !wr_pend && !rd_pend && ret_q.size() == 0 && exp_q.size() == 0
             && model_out == 0 && !bus.app_rd_data_valid_i) done = 1;
      end
      checks++; if (!done) begin errors++; $display("FAIL rnd_drain got wr=%0b rd=%0b ret=%0d exp=%0d want all idle", wr_pend, rd_pend, ret_q.size(), exp_q.size()); end
      clear_inputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_calib_gate();
      test_single_write();
      test_round_robin();
      test_outstanding_limit();
      test_simultaneous();
      test_spurious_and_reset();
      test_random_traffic();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
